// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter; PROG_COUNTER_CAPTURE_EN adds the capture port pair.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  up_down;
  logic                  mode;
  logic                  start;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count_out;
  logic                  tc;
  logic                  busy;
  logic                  done;
`ifdef PROG_COUNTER_CAPTURE_EN
  logic                  capture;
  logic [WIDTH-1:0]      capture_value;

  modport master (
    output en, up_down, mode, start, load, load_value, limit, prescale, capture,
    input  count_out, tc, busy, done, capture_value
  );
  modport slave (
    input  en, up_down, mode, start, load, load_value, limit, prescale, capture,
    output count_out, tc, busy, done, capture_value
  );
`else
  modport master (
    output en, up_down, mode, start, load, load_value, limit, prescale,
    input  count_out, tc, busy, done
  );
  modport slave (
    input  en, up_down, mode, start, load, load_value, limit, prescale,
    output count_out, tc, busy, done
  );
`endif
endinterface

// File: rtl/prog_counter.sv
// Up/down modulo counter with prescaler, parallel load and IDLE/RUN/DONE run control.
// Optional input capture register enabled by PROG_COUNTER_CAPTURE_EN.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  prog_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d, cnt_step;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  tc_q, tc_d;
  logic                  busy_q, done_q;
  logic                  run, tick, wrap;

  // Prescaler and counter only advance while running and enabled.
  assign run  = (state_q == RUN) && bus.en;
  assign tick = run && (psc_q == bus.prescale);

  always_comb begin
    if (bus.up_down) begin
      wrap     = (cnt_q >= bus.limit);
      cnt_step = wrap ? '0 : cnt_q + WIDTH'(1);
    end else begin
      wrap     = (cnt_q == '0);
      cnt_step = wrap ? bus.limit : cnt_q - WIDTH'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
      psc_d = '0;
    end else if (tick) begin
      cnt_d = cnt_step;
      psc_d = '0;
      tc_d  = wrap;
    end else if (run) begin
      psc_d = psc_q + PRESCALE_W'(1);
    end
  end

  // A load edge freezes the FSM; start in RUN is deliberately ignored.
  always_comb begin
    state_d = state_q;
    if (!bus.load) begin
      unique case (state_q)
        IDLE: if ((!bus.mode && bus.en) || (bus.mode && bus.start)) state_d = RUN;
        RUN: begin
          if (!bus.mode && !bus.en)           state_d = IDLE;
          else if (bus.mode && tick && wrap)  state_d = DONE;
        end
        DONE: begin
          if (bus.start)      state_d = RUN;
          else if (!bus.mode) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.count_out = cnt_q;
  assign bus.tc        = tc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef PROG_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  // Samples the registered count, so a coincident load is not seen.
  always_ff @(posedge clk) begin
    if (rst)              cap_q <= '0;
    else if (bus.capture) cap_q <= cnt_q;
  end

  assign bus.capture_value = cap_q;
`endif
endmodule
